// File: rtl/bec_uart_pkg.sv
// bec_uart_pkg: shared types and constants for the BEC UART transmit path.
//   tx_state_t           - transmitter FSM states
//   FRAME_BITS           - serial bits per 8N1 frame (start + 8 data + stop)
//   DEFAULT_CLKS_PER_BIT - 40 MHz system clock / 115200 baud
package bec_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int unsigned FRAME_BITS           = 10;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 347;

endpackage

// File: rtl/bec_tx_fifo.sv
// bec_tx_fifo: generic synchronous FIFO, DEPTH x WIDTH (DEPTH a power of two, >= 2).
// Ports:
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low reset (clears pointers and count)
//   push_i   in   write data_i; ignored while full
//   data_i   in   write data
//   pop_i    in   discard head entry; ignored while empty
//   data_o   out  head entry (valid while !empty_o)
//   full_o   out  no free entry
//   empty_o  out  no stored entry
//   count_o  out  occupancy 0..DEPTH
module bec_tx_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/bec_uart_tx.sv
// bec_uart_tx: buffers 32-bit result words and sends them LSB byte first as 8N1
// frames on a GPIO line.
// Ports:
//   clock    in   system clock, rising edge
//   RSTB     in   asynchronous active-low reset
//   data_i   in   word to send, bits [7:0] go out first
//   valid_i  in   data_i valid; push on valid_i && ready_o
//   ready_o  out  FIFO has a free entry
//   tx_o     out  serial line, idles high, registered
//   busy_o   out  frame in progress or words queued
//   level_o  out  FIFO occupancy
module bec_uart_tx
  import bec_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned WORD_BYTES   = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clock,
  input  logic                          RSTB,
  input  logic [31:0]                   data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int unsigned BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [1:0]  LAST_BYTE = 2'(WORD_BYTES - 1);

  tx_state_t       state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [1:0]      byte_q, byte_d;
  logic [31:0]     shift_q, shift_d;
  logic            tx_q, tx_d;

  logic            baud_wrap;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [31:0]     fifo_data;

  bec_tx_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (RSTB),
    .push_i  (valid_i),
    .data_i  (data_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (level_o)
  );

  assign ready_o   = !fifo_full;
  assign busy_o    = (state_q != IDLE) || !fifo_empty;
  assign tx_o      = tx_q;
  assign baud_wrap = (baud_q == BAUD_LAST);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;

    if (state_q != IDLE) baud_d = baud_wrap ? '0 : baud_q + BW'(1);

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_data;
          baud_d   = '0;
          bit_d    = '0;
          byte_d   = '0;
          state_d  = START;
        end
      end
      START: begin
        if (baud_wrap) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_wrap) begin
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        if (baud_wrap) begin
          if (byte_q < LAST_BYTE) begin
            shift_d = shift_q >> 8;
            byte_d  = byte_q + 2'd1;
            state_d = START;
          end else if (!fifo_empty) begin
            // Chain straight into the next word: no idle bit between frames.
            fifo_pop = 1'b1;
            shift_d  = fifo_data;
            byte_d   = '0;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level follows the current state, so tx_o trails every state change
  // by one clock; this gives the two-edge push-to-start-bit latency.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[bit_q];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge RSTB) begin
    if (!RSTB) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_bec_uart_tx.sv
// tb_bec_uart_tx: three transmitter configurations (A: 4 clk/bit 4 bytes,
// B: 4 clk/bit 1 byte, C: defaults) checked against a timeline model that
// places each accepted word's frame on an absolute cycle axis.
module tb_bec_uart_tx;

  localparam int S_TX = 0, S_RDY = 1, S_BUSY = 2, S_LVL = 3;
  localparam int DEPTH = 4;

  typedef struct {
    int     d;
    int     sig;
    int     at;
    longint exp;
    string  nm;
  } lit_t;

  typedef struct {
    string  nm;
    longint act;
    longint exp;
  } vchk_t;

  logic        clock;
  logic        rstb  [3];
  logic        valid [3];
  logic [31:0] data  [3];
  logic        tx    [3];
  logic        ready [3];
  logic        busy  [3];
  logic [2:0]  level [3];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int timeouts = 0;
  logic final_req = 1'b0;
  logic final_done = 1'b0;

  // model state: per-DUT accepted words and the edge at which each is popped
  int          nw      [3];
  int          pop_t   [3][16];
  logic [31:0] wd      [3][16];
  int          acc_cnt [3];

  lit_t  lits[$];
  vchk_t vchks[$];
  int    rx_log[$];
  int    exp_log[$];

  int          rx_act [3];
  int          rx_cnt [3];
  logic [7:0]  rx_sh  [3];
  logic        prev_tx2 = 1'b1;
  int          f0 = -1;
  int          ntrans = 0;
  int          width_bad = 0;

  bec_uart_tx #(.CLKS_PER_BIT(4), .WORD_BYTES(4), .FIFO_DEPTH(4)) u_a (
    .clock(clock), .RSTB(rstb[0]), .data_i(data[0]), .valid_i(valid[0]),
    .ready_o(ready[0]), .tx_o(tx[0]), .busy_o(busy[0]), .level_o(level[0]));

  bec_uart_tx #(.CLKS_PER_BIT(4), .WORD_BYTES(1), .FIFO_DEPTH(4)) u_b (
    .clock(clock), .RSTB(rstb[1]), .data_i(data[1]), .valid_i(valid[1]),
    .ready_o(ready[1]), .tx_o(tx[1]), .busy_o(busy[1]), .level_o(level[1]));

  bec_uart_tx #(.CLKS_PER_BIT(347), .WORD_BYTES(4), .FIFO_DEPTH(4)) u_c (
    .clock(clock), .RSTB(rstb[2]), .data_i(data[2]), .valid_i(valid[2]),
    .ready_o(ready[2]), .tx_o(tx[2]), .busy_o(busy[2]), .level_o(level[2]));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic int cpb(input int d);
    return (d == 2) ? 347 : 4;
  endfunction

  function automatic int wbytes(input int d);
    return (d == 1) ? 1 : 4;
  endfunction

  function automatic int frame(input int d);
    return wbytes(d) * 10 * cpb(d);
  endfunction

  // ---------------- model ----------------
  function automatic int m_level(input int d, input int t);
    int n = 0;
    for (int i = 0; i < nw[d]; i++) if (pop_t[d][i] > t) n++;
    return n;
  endfunction

  function automatic int m_busy(input int d, input int t);
    for (int i = 0; i < nw[d]; i++) if (pop_t[d][i] + frame(d) > t) return 1;
    return 0;
  endfunction

  // Line after edge t: frame of a word popped at edge P spans edges P+1..P+F.
  function automatic int m_tx(input int d, input int t);
    int o, b, pos;
    for (int i = 0; i < nw[d]; i++) begin
      if (t >= pop_t[d][i] + 1 && t <= pop_t[d][i] + frame(d)) begin
        o   = t - pop_t[d][i] - 1;
        b   = o / (10 * cpb(d));
        pos = (o % (10 * cpb(d))) / cpb(d);
        if (pos == 0) return 0;
        if (pos == 9) return 1;
        return int'(wd[d][i][b*8 + pos - 1]);
      end
    end
    return 1;
  endfunction

  always @(posedge clock) begin
    cyc = cyc + 1;
    for (int d = 0; d < 3; d++) begin
      if (!rstb[d]) begin
        nw[d] = 0;
      end else if (valid[d] && m_level(d, cyc - 1) < DEPTH && nw[d] < 16) begin
        int p;
        p = cyc + 1;
        if (nw[d] > 0 && pop_t[d][nw[d]-1] + frame(d) > p) p = pop_t[d][nw[d]-1] + frame(d);
        pop_t[d][nw[d]] = p;
        wd[d][nw[d]]    = data[d];
        nw[d]           = nw[d] + 1;
        acc_cnt[d]      = acc_cnt[d] + 1;
      end
    end
  end

  // ---------------- receiver ----------------
  always @(negedge clock) begin
    for (int d = 0; d < 3; d++) begin
      if (!rstb[d]) begin
        rx_act[d] = 0;
      end else if (rx_act[d] == 0) begin
        if (tx[d] == 1'b0) begin
          rx_act[d] = 1;
          rx_cnt[d] = 0;
        end
      end else begin
        rx_cnt[d] = rx_cnt[d] + 1;
        if (rx_cnt[d] % cpb(d) == cpb(d) / 2) begin
          int i;
          i = rx_cnt[d] / cpb(d);
          if (i >= 1 && i <= 8) rx_sh[d][i-1] = tx[d];
          if (i == 9) begin
            rx_log.push_back(d * 256 + int'(rx_sh[d]));
            rx_act[d] = 0;
          end
        end
      end
    end
    if (rstb[2]) begin
      if (tx[2] !== prev_tx2) begin
        if (f0 < 0) f0 = cyc;
        else if ((cyc - f0) % 347 != 0) width_bad++;
        ntrans++;
      end
      prev_tx2 = tx[2];
    end
  end

  // ---------------- compare ----------------
  task automatic chk(input string nm, input int d, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut=%0d cyc=%0d got=%0h expected=%0h", nm, d, cyc, act, exp);
    end
  endtask

  function automatic longint sig_val(input int d, input int s);
    case (s)
      S_TX:    return longint'(tx[d]);
      S_RDY:   return longint'(ready[d]);
      S_BUSY:  return longint'(busy[d]);
      default: return longint'(level[d]);
    endcase
  endfunction

  always @(negedge clock) begin
    if (!final_done) begin
      for (int d = 0; d < 3; d++) begin
        int lv;
        lv = rstb[d] ? m_level(d, cyc) : 0;
        chk("tx",    d, longint'(tx[d]),    rstb[d] ? m_tx(d, cyc) : 1);
        chk("level", d, longint'(level[d]), lv);
        chk("ready", d, longint'(ready[d]), (lv < DEPTH) ? 1 : 0);
        chk("busy",  d, longint'(busy[d]),  rstb[d] ? m_busy(d, cyc) : 0);
      end
      foreach (lits[i]) begin
        if (lits[i].at == cyc) chk(lits[i].nm, lits[i].d, sig_val(lits[i].d, lits[i].sig), lits[i].exp);
      end
      if (final_req) begin
        chk("rx_count", -1, rx_log.size(), exp_log.size());
        for (int i = 0; i < rx_log.size() && i < exp_log.size(); i++)
          chk("rx_byte", exp_log[i] / 256, rx_log[i], exp_log[i]);
        foreach (vchks[i]) chk(vchks[i].nm, -1, vchks[i].act, vchks[i].exp);
        chk("push_timeouts", -1, timeouts, 0);
        chk("bit_grid_347", 2, width_bad, 0);
        chk("c_line_active", 2, (ntrans > 0) ? 1 : 0, 1);
        final_done = 1'b1;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic add_lit(input int d, input int s, input int at, input longint e, input string nm);
    lit_t l;
    l.d = d; l.sig = s; l.at = at; l.exp = e; l.nm = nm;
    lits.push_back(l);
  endtask

  task automatic add_vchk(input string nm, input longint a, input longint e);
    vchk_t v;
    v.nm = nm; v.act = a; v.exp = e;
    vchks.push_back(v);
  endtask

  task automatic exp_word(input int d, input logic [31:0] w, input int nb);
    for (int b = 0; b < nb; b++) exp_log.push_back(d * 256 + int'((w >> (8 * b)) & 32'hFF));
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push(input int d, input logic [31:0] w, output int at);
    int n0, guard;
    @(negedge clock);
    valid[d] = 1'b1;
    data[d]  = w;
    n0    = acc_cnt[d];
    guard = 0;
    do begin
      @(posedge clock);
      #1;
      guard++;
    end while (acc_cnt[d] == n0 && guard < 20000);
    if (acc_cnt[d] == n0) timeouts++;
    valid[d] = 1'b0;
    data[d]  = $urandom;
    at = cyc;
  endtask

  initial begin
    int k;
    int a [6];
    int guard;
    for (int d = 0; d < 3; d++) begin
      rstb[d] = 1'b0; valid[d] = 1'b0; data[d] = '0;
      nw[d] = 0; acc_cnt[d] = 0; rx_act[d] = 0; rx_cnt[d] = 0; rx_sh[d] = '0;
    end

    // reset state
    repeat (2) @(posedge clock);
    #1;
    for (int d = 0; d < 3; d++) begin
      add_lit(d, S_TX,   cyc, 1, "reset_tx");
      add_lit(d, S_RDY,  cyc, 1, "reset_ready");
      add_lit(d, S_BUSY, cyc, 0, "reset_busy");
      add_lit(d, S_LVL,  cyc, 0, "reset_level");
    end
    @(posedge clock);
    #1;
    for (int d = 0; d < 3; d++) rstb[d] = 1'b1;

    // single word on A
    push(0, 32'hAB40_1234, k);
    add_lit(0, S_TX,   k + 1,   1, "single_tx_k1");
    add_lit(0, S_TX,   k + 2,   0, "single_tx_k2_start");
    add_lit(0, S_BUSY, k + 160, 1, "single_busy_last");
    add_lit(0, S_BUSY, k + 161, 0, "single_busy_fall");
    exp_word(0, 32'hAB40_1234, 4);
    wait_until(k + 170);

    // back-pressure on A
    for (int i = 0; i < 6; i++) begin
      logic [31:0] w;
      w = 32'hA0B0_C0D0 + 32'h0101_0101 * i;
      push(0, w, a[i]);
      exp_word(0, w, 4);
      if (i == 0) begin
        add_lit(0, S_LVL, a[0] + 4,   4, "bp_level_full");
        add_lit(0, S_RDY, a[0] + 4,   0, "bp_ready_low");
        add_lit(0, S_RDY, a[0] + 160, 0, "bp_ready_still_low");
        add_lit(0, S_RDY, a[0] + 161, 1, "bp_ready_back");
        add_lit(0, S_TX,  a[0] + 161, 1, "bp_stop_bit");
        add_lit(0, S_TX,  a[0] + 162, 0, "bp_no_gap_start");
      end
    end
    for (int i = 1; i < 5; i++) add_vchk("bp_accept_gap", a[i] - a[0], i);
    add_vchk("bp_sixth_accept", a[5] - a[0], 162);
    wait_until(a[0] + 1 + 960 + 10);

    // reset during byte 2 data bits on A
    push(0, 32'hDEAD_BEEF, k);
    push(0, 32'h55AA_55AA, a[0]);
    exp_word(0, 32'hDEAD_BEEF, 2);
    wait_until(k + 92);
    rstb[0] = 1'b0;
    add_lit(0, S_TX,   cyc, 1, "rst_mid_tx");
    add_lit(0, S_LVL,  cyc, 0, "rst_mid_level");
    add_lit(0, S_BUSY, cyc, 0, "rst_mid_busy");
    add_lit(0, S_RDY,  cyc, 1, "rst_mid_ready");
    repeat (2) @(posedge clock);
    #1;
    rstb[0] = 1'b1;
    push(0, 32'h0000_00A5, k);
    add_lit(0, S_TX, k + 2, 0, "after_rst_start");
    exp_word(0, 32'h0000_00A5, 4);
    wait_until(k + 170);

    // idle noise on A
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      data[0] = $urandom;
    end
    @(posedge clock);
    #1;
    add_lit(0, S_TX,   cyc, 1, "noise_tx");
    add_lit(0, S_LVL,  cyc, 0, "noise_level");
    add_lit(0, S_BUSY, cyc, 0, "noise_busy");

    // one byte per word on B
    push(1, 32'h1234_5678, k);
    add_lit(1, S_TX,   k + 1,  1, "wb1_tx_k1");
    add_lit(1, S_TX,   k + 2,  0, "wb1_start");
    add_lit(1, S_BUSY, k + 40, 1, "wb1_busy_last");
    add_lit(1, S_BUSY, k + 41, 0, "wb1_busy_fall");
    exp_word(1, 32'h1234_5678, 1);
    wait_until(k + 60);

    // default baud on C
    push(2, 32'hAB51_AB41, k);
    add_lit(2, S_TX,   k + 2,     0, "baud_start");
    add_lit(2, S_BUSY, k + 13880, 1, "baud_busy_last");
    add_lit(2, S_BUSY, k + 13881, 0, "baud_busy_fall");
    exp_word(2, 32'hAB51_AB41, 4);
    wait_until(k + 13900);

    final_req = 1'b1;
    guard = 0;
    while (!final_done && guard < 10) begin
      @(posedge clock);
      guard++;
    end
    if (!final_done) $display("FAIL final_check never ran (budget 10 cycles)");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
